// File: rtl/expr_result_unpacker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : expr_result_unpacker
// Purpose  : Captures one 90-bit packed expression-result word {y0..y17} over a
//            valid/ready handshake and streams its 18 fields one per beat,
//            each widened to OUT_W bits (zero- or sign-extended).
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready/in_data[89:0]      packed word input
//            out_valid/out_ready                  beat handshake
//            out_data[OUT_W-1:0]                  extended field
//            out_idx[4:0]                         field index (18 = checksum)
//            out_last                             final beat of the word
// Options  : EXPR_UNPACK_CHECKSUM_EN - appends a beat carrying the XOR of the
//            18 extended field values; out_last moves to that beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module expr_result_unpacker #(
   parameter int OUT_W    = 8,
   parameter bit SIGN_EXT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [89:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [4:0]       out_idx,
   output logic             out_last
);

`ifdef EXPR_UNPACK_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_SUM = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1} state_t;
`endif

   state_t           r_state;
   logic [89:0]      r_sr;
   logic [4:0]       r_idx;
   logic             r_out_valid;
   logic             r_in_ready;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_last;
`ifdef EXPR_UNPACK_CHECKSUM_EN
   logic [OUT_W-1:0] r_acc;
`endif

   logic [89:0]      w_sr_next;
   logic [4:0]       w_idx_next;

   // Field k is 4, 5 or 6 bits wide, cycling with k.
   function automatic logic [6:0] f_width(input logic [4:0] k);
      f_width = 7'd4 + 7'(k % 5'd3);
   endfunction

   // The current field always sits at the top of the shift register.
   function automatic logic [OUT_W-1:0] f_field(input logic [89:0] sr, input logic [4:0] k);
      logic sgn;
      sgn     = SIGN_EXT && ((k % 5'd6) >= 5'd3);
      f_field = '0;
      case (k % 5'd3)
         5'd0: begin
            if (sgn) f_field = OUT_W'($signed(sr[89:86]));
            else     f_field = OUT_W'(sr[89:86]);
         end
         5'd1: begin
            if (sgn) f_field = OUT_W'($signed(sr[89:85]));
            else     f_field = OUT_W'(sr[89:85]);
         end
         default: begin
            if (sgn) f_field = OUT_W'($signed(sr[89:84]));
            else     f_field = OUT_W'(sr[89:84]);
         end
      endcase
   endfunction

   assign w_sr_next  = r_sr << f_width(r_idx);
   assign w_idx_next = r_idx + 5'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
`ifdef EXPR_UNPACK_CHECKSUM_EN
         r_acc       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  // Beat 0 is presented straight from the captured word.
                  r_sr        <= in_data;
                  r_idx       <= 5'd0;
                  r_out_data  <= f_field(in_data, 5'd0);
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= S_STREAM;
`ifdef EXPR_UNPACK_CHECKSUM_EN
                  r_acc       <= '0;
`endif
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  r_sr <= w_sr_next;
`ifdef EXPR_UNPACK_CHECKSUM_EN
                  r_acc <= r_acc ^ r_out_data;
`endif
                  if (r_idx == 5'd17) begin
`ifdef EXPR_UNPACK_CHECKSUM_EN
                     // Checksum folds in the field-17 beat being accepted now.
                     r_idx      <= 5'd18;
                     r_out_data <= r_acc ^ r_out_data;
                     r_out_last <= 1'b1;
                     r_state    <= S_SUM;
`else
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_out_last  <= 1'b0;
                     r_state     <= S_IDLE;
`endif
                  end else begin
                     r_idx      <= w_idx_next;
                     r_out_data <= f_field(w_sr_next, w_idx_next);
`ifdef EXPR_UNPACK_CHECKSUM_EN
                     r_out_last <= 1'b0;
`else
                     r_out_last <= (r_idx == 5'd16);
`endif
                  end
               end
            end
`ifdef EXPR_UNPACK_CHECKSUM_EN
            S_SUM: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_out_last  <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
`endif
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_out_last  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_idx;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_expr_result_unpacker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_expr_result_unpacker
// Purpose  : Scoreboard bench for expr_result_unpacker. The driver pushes the
//            expected beats of every captured word into a queue; a monitor on
//            the falling edge pops and compares each accepted beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_expr_result_unpacker;

   localparam int OUT_W    = 8;
   localparam bit SIGN_EXT = 1'b1;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic [4:0]       i;
      logic             l;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [89:0]      in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic [4:0]       out_idx;
   logic             out_last;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    rdy_mode = 1;   // 0 manual, 1 always high, 2 random
   int    last_hs_cyc = -100;
   bit    chk_lat = 1'b0;
   beat_t q[$];
   bit    held = 1'b0;
   beat_t saved;

   expr_result_unpacker #(.OUT_W(OUT_W), .SIGN_EXT(SIGN_EXT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: walk the fields from the MSB with plain arithmetic.
   task automatic push_word(input logic [89:0] w);
      int pos;
      logic [OUT_W-1:0] x;
      pos = 90;
      x   = '0;
      for (int k = 0; k < 18; k++) begin
         int wd, v;
         logic [89:0] t;
         beat_t b;
         wd  = 4 + (k % 3);
         pos = pos - wd;
         t   = w >> pos;
         v   = int'(t[5:0]) & ((1 << wd) - 1);
         if (SIGN_EXT && (k % 6) >= 3 && v >= (1 << (wd - 1))) v = v - (1 << wd);
         b.d = OUT_W'(v);
         b.i = 5'(k);
`ifdef EXPR_UNPACK_CHECKSUM_EN
         b.l = 1'b0;
`else
         b.l = (k == 17);
`endif
         x = x ^ b.d;
         q.push_back(b);
      end
`ifdef EXPR_UNPACK_CHECKSUM_EN
      q.push_back('{d: x, i: 5'd18, l: 1'b1});
`endif
   endtask

   task automatic send_word(input logic [89:0] w);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            push_word(w);
            if (chk_lat) chk("capture_after_last", 32'(cyc - last_hs_cyc), 32'd1);
            done = 1'b1;
         end
      end
      if (!done) chk("capture_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   function automatic logic [89:0] rnd_word();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[89:0];
   endfunction

   // Waits (bounded) until out_idx shows idx with out_valid, sampled 1 after posedge.
   task automatic wait_idx(input logic [4:0] idx, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_idx == idx) ok = 1'b1;
      end
      if (!ok) chk("wait_idx_timeout", 32'(idx), 32'd99);
   endtask

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
         else if (rdy_mode == 1) out_ready = 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (out_valid) begin
         chk("in_ready_low_while_streaming", 32'(in_ready), 32'd0);
         if (held) begin
            chk("stall_data", 32'(out_data), 32'(saved.d));
            chk("stall_idx",  32'(out_idx),  32'(saved.i));
            chk("stall_last", 32'(out_last), 32'(saved.l));
         end
         if (out_ready) begin
            held = 1'b0;
            if (out_last) last_hs_cyc = cyc + 1;
            if (q.size() == 0) begin
               chk("unexpected_beat", 32'(out_idx), 32'hFFFF);
            end else begin
               beat_t e;
               e = q.pop_front();
               chk("beat_idx",  32'(out_idx),  32'(e.i));
               chk("beat_data", 32'(out_data), 32'(e.d));
               chk("beat_last", 32'(out_last), 32'(e.l));
            end
         end else begin
            held    = 1'b1;
            saved.d = out_data;
            saved.i = out_idx;
            saved.l = out_last;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      bit ok;
      logic [89:0] w;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_out_data",  32'(out_data),  32'd0);
      chk("reset_out_idx",   32'(out_idx),   32'd0);
      chk("reset_out_last",  32'(out_last),  32'd0);

      // All ones: repeating 0F,1F,3F,FF,FF,FF
      rdy_mode = 1;
      send_word({90{1'b1}});
      // Single-field words: y0=A, then y3=1000 (expects F8)
      w = '0; w[89:86] = 4'hA;   send_word(w);
      w = '0; w[74:71] = 4'b1000; send_word(w);

      // Back-to-back with out_ready high: capture exactly one cycle after last beat
      send_word(rnd_word());
      chk_lat = 1'b1;
      send_word(rnd_word());
      chk_lat = 1'b0;

      // Hold out_ready low for 3 cycles while idx 5 is presented
      send_word(rnd_word());
      rdy_mode = 0;
      out_ready = 1'b1;
      wait_idx(5'd5, ok);
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("hold_idx5", 32'(out_idx), 32'd5);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_idx6", 32'(out_idx), 32'd6);
      rdy_mode = 1;

      // Reset while idx 7 is presented abandons the word
      send_word(rnd_word());
      wait_idx(5'd7, ok);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
      chk("rst_mid_out_idx",   32'(out_idx),   32'd0);
      send_word(rnd_word());

      // Random words under random backpressure
      rdy_mode = 2;
      for (int n = 0; n < 30; n++) send_word(rnd_word());

      // Drain
      for (int n = 0; n < 3000 && (q.size() != 0 || out_valid); n++) @(posedge clk);
      #1;
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
